// File: rtl/pipe_pkg.sv
// Shared types for the pipeline register stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage.sv
// Two-entry pipeline stage (main + skid register) with flush, ctrl gating and a
// saturating stall counter. in_ready depends only on registered state.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned CTRL_W        = 8,
  parameter int unsigned CNT_W         = 16,
  parameter bit          ZERO_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              in_fire, out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign stall_cnt = stall_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    unique case (state_q)
      HALF:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
          state_d     = HALF;
        end
      end
      HALF: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (in_fire) begin
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
          state_d     = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          state_d     = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush overrides everything, including an entry accepted this cycle.
    if (flush) begin
      state_d = EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_data_d = '0;
        main_ctrl_d = '0;
        skid_data_d = '0;
        skid_ctrl_d = '0;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_pipe_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 4;
  localparam int          StallMax = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage #(
    .DATA_W       (DW),
    .CTRL_W       (CW),
    .CNT_W        (SW),
    .ZERO_ON_FLUSH(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t q[$];
  int   exp_stall;
  bit   zero_known;  // main register known to hold zero (after reset/flush)
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_ctrl;
    exp_ctrl = 0;
    if (q.size() > 0) exp_ctrl = 32'(q[0].c);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("out_ctrl", 32'(out_ctrl), exp_ctrl);
    if (q.size() > 0) chk("out_data", out_data, q[0].d);
    else if (zero_known) chk("out_data_zero", out_data, 0);
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
  endtask

  task automatic model_reset();
    q.delete();
    exp_stall  = 0;
    zero_known = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check #1 later.
  task automatic step(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input bit orr, input bit fl);
    bit acc;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = orr;
    flush     = fl;
    @(posedge clk);
    if (q.size() > 0 && !orr && exp_stall < StallMax) exp_stall++;
    if (fl) begin
      q.delete();
      zero_known = 1'b1;
    end else begin
      acc = iv && (q.size() < 2);
      if (q.size() > 0 && orr) begin
        void'(q.pop_front());
        zero_known = 1'b0;
      end
      if (acc) q.push_back('{d: d, c: c});
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0; flush = 1'b0;
    #1;
    model_reset();
    check_all();
    #12 rst = 1'b1;

    // Streaming: one transfer per cycle, occupancy stays 1.
    step(1, 32'd1, 8'h01, 1, 0);
    step(1, 32'd2, 8'h02, 1, 0);
    step(1, 32'd3, 8'h03, 1, 0);
    step(0, 32'd0, 8'h00, 1, 0);

    // Skid: A held, B goes to skid, C refused, then drain in order.
    step(1, 32'hA, 8'h0A, 0, 0);
    step(1, 32'hB, 8'h0B, 0, 0);
    step(1, 32'hC, 8'h0C, 0, 0);
    step(1, 32'hC, 8'h0C, 1, 0);
    step(0, 32'h0, 8'h00, 1, 0);
    step(0, 32'h0, 8'h00, 1, 0);
    step(0, 32'h0, 8'h00, 1, 0);

    // Flush while full with a simultaneous offer of 0xD.
    step(1, 32'hE, 8'h0E, 0, 0);
    step(1, 32'hF, 8'h0F, 0, 0);
    step(1, 32'hD, 8'h0D, 0, 1);
    step(0, 32'h0, 8'h00, 1, 0);

    // Ctrl gating.
    step(1, 32'h77, 8'hFF, 0, 0);
    step(0, 32'h0, 8'h00, 1, 0);
    step(0, 32'h0, 8'h00, 1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom, 8'($urandom), ($urandom % 3) != 0,
           ($urandom % 20) == 0);
    end

    // Async reset while full, asserted between edges.
    step(0, 32'h0, 8'h00, 1, 1);
    step(1, 32'h11, 8'h21, 0, 0);
    step(1, 32'h12, 8'h22, 0, 0);
    chk("full_before_reset", 32'(occupancy), 2);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    in_valid = 1'b1; in_data = 32'h99; in_ctrl = 8'h99; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    #2 rst = 1'b1;
    step(1, 32'h55, 8'h5A, 0, 0);

    // Stall counter saturation (CNT_W=4).
    for (int i = 0; i < 20; i++) step(0, 32'h0, 8'h00, 0, 0);
    chk("stall_sat", 32'(stall_cnt), 15);
    step(0, 32'h0, 8'h00, 0, 1);
    chk("stall_kept_by_flush", 32'(stall_cnt), 15);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
